// File: rtl/byte_ram_master.sv
// byte_ram_master: host-side initiator for the 8x16 byte-enable RAM.
// Accepts byte/halfword reads and writes at byte granularity and returns one
// response per request. Build macro BYTE_RAM_MASTER_SPLIT_EN: when defined,
// misaligned halfwords are split into two RAM accesses (wrapping the word
// address); when undefined they are rejected with rsp_err and touch no RAM.
module byte_ram_master #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [1:0]        mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data_in,
  input  logic [15:0]       mem_data_out
);

  typedef enum logic [2:0] {IDLE, ISSUE1, ISSUE2, CAP1, CAP2, RESP} state_t;

  state_t state;
  logic   wr_q;
  logic   size_q;
  logic   lane_q;
  logic   reject;

`ifdef BYTE_RAM_MASTER_SPLIT_EN
  localparam logic [ADDR_W-1:0] WORD_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] word_q;
  logic [7:0]        wdata_hi_q;
  logic [7:0]        d1_hi_q;

  assign reject = 1'b0;
`else
  assign reject = req_size && req_addr[0];
`endif

  // Lane enables for the first (or only) RAM access of a write.
  function automatic logic [1:0] first_be(input logic size, input logic lane);
    if (size && !lane) return 2'b11;
    return lane ? 2'b10 : 2'b01;
  endfunction

  // Write data for the first access; single bytes are replicated on both lanes.
  function automatic logic [15:0] first_data(input logic size, input logic lane,
                                             input logic [15:0] wdata);
    if (size && !lane) return wdata;
    return {wdata[7:0], wdata[7:0]};
  endfunction

  // Read data for a single-access read; bytes are zero-extended.
  function automatic logic [15:0] read_data(input logic size, input logic lane,
                                            input logic [15:0] d);
    if (size) return d;
    return {8'h00, lane ? d[15:8] : d[7:0]};
  endfunction

  // Request sequencer: every host and RAM output is registered on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= 16'h0000;
      rsp_err     <= 1'b0;
      mem_we      <= 1'b0;
      mem_byte_en <= 2'b00;
      mem_addr    <= '0;
      mem_data_in <= 16'h0000;
      wr_q        <= 1'b0;
      size_q      <= 1'b0;
      lane_q      <= 1'b0;
`ifdef BYTE_RAM_MASTER_SPLIT_EN
      word_q      <= '0;
      wdata_hi_q  <= 8'h00;
      d1_hi_q     <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q      <= req_write;
            size_q    <= req_size;
            lane_q    <= req_addr[0];
            req_ready <= 1'b0;
`ifdef BYTE_RAM_MASTER_SPLIT_EN
            word_q     <= req_addr[ADDR_W:1];
            wdata_hi_q <= req_wdata[15:8];
`endif
            if (reject) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 16'h0000;
            end else begin
              state       <= ISSUE1;
              mem_addr    <= req_addr[ADDR_W:1];
              mem_we      <= req_write;
              mem_byte_en <= req_write ? first_be(req_size, req_addr[0]) : 2'b00;
              mem_data_in <= req_write ? first_data(req_size, req_addr[0], req_wdata)
                                       : 16'h0000;
            end
          end
        end
        ISSUE1: begin
`ifdef BYTE_RAM_MASTER_SPLIT_EN
          if (wr_q && size_q && lane_q) begin
            state       <= ISSUE2;
            mem_addr    <= word_q + WORD_ONE;
            mem_we      <= 1'b1;
            mem_byte_en <= 2'b01;
            mem_data_in <= {wdata_hi_q, wdata_hi_q};
          end else
`endif
          if (wr_q) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= 16'h0000;
            mem_we      <= 1'b0;
            mem_byte_en <= 2'b00;
            mem_data_in <= 16'h0000;
          end else begin
            state <= CAP1;
`ifdef BYTE_RAM_MASTER_SPLIT_EN
            if (size_q && lane_q) mem_addr <= word_q + WORD_ONE;
`endif
          end
        end
`ifdef BYTE_RAM_MASTER_SPLIT_EN
        ISSUE2: begin
          state       <= RESP;
          rsp_valid   <= 1'b1;
          rsp_data    <= 16'h0000;
          mem_we      <= 1'b0;
          mem_byte_en <= 2'b00;
          mem_data_in <= 16'h0000;
        end
        CAP2: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= {mem_data_out[7:0], d1_hi_q};
        end
`endif
        CAP1: begin
`ifdef BYTE_RAM_MASTER_SPLIT_EN
          if (size_q && lane_q) begin
            d1_hi_q <= mem_data_out[15:8];
            state   <= CAP2;
          end else
`endif
          begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= read_data(size_q, lane_q, mem_data_out);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_ram_master.sv
// tb_byte_ram_master: directed bench for byte_ram_master with a behavioural
// 8x16 byte-enable RAM (registered read, old data on same-address write).
module tb_byte_ram_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_size;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic        mem_we;
  logic [1:0]  mem_byte_en;
  logic [2:0]  mem_addr;
  logic [15:0] mem_data_in, mem_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ram [0:7];
  logic        ram_init;
  int          we_cnt = 0;

  // snapshot of one transaction
  int          lat, acc_wait;
  logic        we1, we2, err_o;
  logic [1:0]  be1, be2;
  logic [2:0]  a1, a2;
  logic [15:0] d1, d2, data_o;

  byte_ram_master #(.ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_byte_en(mem_byte_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // RAM model: initial contents ram[k] = 16'h0101*k
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 8; k++) ram[k] <= 16'(k * 257);
    end else begin
      if (mem_we) begin
        if (mem_byte_en[0]) ram[mem_addr][7:0]  <= mem_data_in[7:0];
        if (mem_byte_en[1]) ram[mem_addr][15:8] <= mem_data_in[15:8];
        we_cnt <= we_cnt + 1;
      end
    end
    mem_data_out <= ram[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got 200000 want finish earlier");
    $fatal(1, "watchdog");
  end

  // Issue one request, record first/second cycle RAM outputs and the response.
  task automatic do_req(input logic wr, input logic sz, input logic [3:0] addr,
                        input logic [15:0] wd, input bit hold);
    acc_wait = 0;
    @(negedge clk);
    while (!req_ready && acc_wait < 10) begin @(negedge clk); acc_wait++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 12) begin
      @(negedge clk); lat++;
      if (lat == 1) begin we1 = mem_we; be1 = mem_byte_en; a1 = mem_addr; d1 = mem_data_in; end
      if (lat == 2) begin we2 = mem_we; be2 = mem_byte_en; a2 = mem_addr; d2 = mem_data_in; end
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: rsp_valid got %b want 1", rsp_valid);
    end
    data_o = rsp_data; err_o = rsp_err;
    if (!hold) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 ram_init = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, mem_we, mem_byte_en, mem_addr} !== 9'b1_0_0_0_00_000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 100000000",
               {req_ready, rsp_valid, rsp_err, mem_we, mem_byte_en, mem_addr});
    end
    n_cmp++; if (rsp_data !== 16'h0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    n_cmp++; if (mem_data_in !== 16'h0) begin n_bad++; $display("FAIL reset_mem_data_in: got %h want 0000", mem_data_in); end
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_halfword;
    do_req(1'b1, 1'b1, 4'h4, 16'hBEEF, 1'b0);
    n_cmp++; if ({we1, be1, a1} !== {1'b1, 2'b11, 3'd2}) begin n_bad++; $display("FAIL hw_wr_issue: got %b want 111010", {we1, be1, a1}); end
    n_cmp++; if (d1 !== 16'hBEEF) begin n_bad++; $display("FAIL hw_wr_data_in: got %h want beef", d1); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hw_wr_latency: got %0d want 2", lat); end
    n_cmp++; if ({err_o, data_o} !== 17'h0) begin n_bad++; $display("FAIL hw_wr_rsp: got %b/%h want 0/0000", err_o, data_o); end
    n_cmp++; if (ram[2] !== 16'hBEEF) begin n_bad++; $display("FAIL hw_wr_ram: got %h want beef", ram[2]); end
    do_req(1'b0, 1'b1, 4'h4, 16'h0000, 1'b0);
    n_cmp++; if ({we1, be1, a1} !== {1'b0, 2'b00, 3'd2}) begin n_bad++; $display("FAIL hw_rd_issue: got %b want 000010", {we1, be1, a1}); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL hw_rd_latency: got %0d want 3", lat); end
    n_cmp++; if ({err_o, data_o} !== {1'b0, 16'hBEEF}) begin n_bad++; $display("FAIL hw_rd_rsp: got %b/%h want 0/beef", err_o, data_o); end
  endtask

  task automatic test_byte_lanes;
    do_req(1'b1, 1'b0, 4'h5, 16'h0012, 1'b0);
    n_cmp++; if ({we1, be1, a1} !== {1'b1, 2'b10, 3'd2}) begin n_bad++; $display("FAIL b_wr_hi_issue: got %b want 110010", {we1, be1, a1}); end
    n_cmp++; if (d1 !== 16'h1212) begin n_bad++; $display("FAIL b_wr_hi_data_in: got %h want 1212", d1); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL b_wr_latency: got %0d want 2", lat); end
    n_cmp++; if (ram[2] !== 16'h12EF) begin n_bad++; $display("FAIL b_wr_hi_ram: got %h want 12ef", ram[2]); end
    do_req(1'b0, 1'b1, 4'h4, 16'h0000, 1'b0);
    n_cmp++; if (data_o !== 16'h12EF) begin n_bad++; $display("FAIL hw_rd_after_byte: got %h want 12ef", data_o); end
    do_req(1'b0, 1'b0, 4'h4, 16'h0000, 1'b0);
    n_cmp++; if (data_o !== 16'h00EF) begin n_bad++; $display("FAIL b_rd_lo: got %h want 00ef", data_o); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b_rd_latency: got %0d want 3", lat); end
    do_req(1'b0, 1'b0, 4'h5, 16'h0000, 1'b0);
    n_cmp++; if (data_o !== 16'h0012) begin n_bad++; $display("FAIL b_rd_hi: got %h want 0012", data_o); end
    do_req(1'b1, 1'b0, 4'h4, 16'hAB34, 1'b0);
    n_cmp++; if ({be1, d1} !== {2'b01, 16'h3434}) begin n_bad++; $display("FAIL b_wr_lo_issue: got %b/%h want 01/3434", be1, d1); end
    n_cmp++; if (ram[2] !== 16'h1234) begin n_bad++; $display("FAIL b_wr_lo_ram: got %h want 1234", ram[2]); end
  endtask

`ifdef BYTE_RAM_MASTER_SPLIT_EN
  task automatic test_misaligned;
    do_req(1'b1, 1'b1, 4'hF, 16'hA55A, 1'b0);
    n_cmp++; if ({we1, be1, a1, d1[15:8]} !== {1'b1, 2'b10, 3'd7, 8'h5A}) begin n_bad++; $display("FAIL split_wr_first: got %b/%h want 110111/5a", {we1, be1, a1}, d1[15:8]); end
    n_cmp++; if ({we2, be2, a2, d2[7:0]} !== {1'b1, 2'b01, 3'd0, 8'hA5}) begin n_bad++; $display("FAIL split_wr_second: got %b/%h want 101000/a5", {we2, be2, a2}, d2[7:0]); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL split_wr_latency: got %0d want 3", lat); end
    n_cmp++; if ({ram[7], ram[0]} !== {16'h5A07, 16'h00A5}) begin n_bad++; $display("FAIL split_wr_ram: got %h %h want 5a07 00a5", ram[7], ram[0]); end
    do_req(1'b0, 1'b1, 4'hF, 16'h0000, 1'b0);
    n_cmp++; if ({a1, a2} !== {3'd7, 3'd0}) begin n_bad++; $display("FAIL split_rd_addrs: got %0d %0d want 7 0", a1, a2); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL split_rd_latency: got %0d want 4", lat); end
    n_cmp++; if ({err_o, data_o} !== {1'b0, 16'hA55A}) begin n_bad++; $display("FAIL split_rd_rsp: got %b/%h want 0/a55a", err_o, data_o); end
    do_req(1'b0, 1'b1, 4'h5, 16'h0000, 1'b0);
    n_cmp++; if (data_o !== 16'h0312) begin n_bad++; $display("FAIL split_rd_mid: got %h want 0312", data_o); end
  endtask
`else
  task automatic test_misaligned;
    int cnt0;
    cnt0 = we_cnt;
    do_req(1'b1, 1'b1, 4'h3, 16'hFFFF, 1'b0);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rej_wr_latency: got %0d want 1", lat); end
    n_cmp++; if ({err_o, data_o} !== {1'b1, 16'h0000}) begin n_bad++; $display("FAIL rej_wr_rsp: got %b/%h want 1/0000", err_o, data_o); end
    n_cmp++; if ({we1, we_cnt} !== {1'b0, cnt0}) begin n_bad++; $display("FAIL rej_wr_no_access: got we %b count %0d want 0 %0d", we1, we_cnt, cnt0); end
    n_cmp++; if ({ram[1], ram[2]} !== {16'h0101, 16'h1234}) begin n_bad++; $display("FAIL rej_wr_ram: got %h %h want 0101 1234", ram[1], ram[2]); end
    do_req(1'b0, 1'b1, 4'h7, 16'h0000, 1'b0);
    n_cmp++; if ({lat[3:0], err_o, data_o} !== {4'd1, 1'b1, 16'h0000}) begin n_bad++; $display("FAIL rej_rd: got lat %0d %b/%h want 1 1/0000", lat, err_o, data_o); end
    do_req(1'b0, 1'b1, 4'h2, 16'h0000, 1'b0);
    n_cmp++; if ({lat[3:0], err_o, data_o} !== {4'd3, 1'b0, 16'h0101}) begin n_bad++; $display("FAIL after_rej_rd: got lat %0d %b/%h want 3 0/0101", lat, err_o, data_o); end
  endtask
`endif

  task automatic test_back_to_back;
    do_req(1'b1, 1'b0, 4'h8, 16'h005C, 1'b0);
    do_req(1'b0, 1'b0, 4'h9, 16'h0000, 1'b0);
    n_cmp++; if (acc_wait !== 0) begin n_bad++; $display("FAIL b2b_accept: got wait %0d want 0", acc_wait); end
    n_cmp++; if (data_o !== 16'h0004) begin n_bad++; $display("FAIL b2b_rd_hi: got %h want 0004", data_o); end
    n_cmp++; if (ram[4] !== 16'h045C) begin n_bad++; $display("FAIL b2b_ram: got %h want 045c", ram[4]); end
  endtask

  task automatic test_rsp_hold;
    int cnt0;
    int w;
    rsp_ready = 1'b0;
    do_req(1'b0, 1'b1, 4'h4, 16'h0000, 1'b1);
    n_cmp++; if (data_o !== 16'h1234) begin n_bad++; $display("FAIL hold_rd: got %h want 1234", data_o); end
    cnt0 = we_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 4'h0; req_wdata = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_data} !== {1'b1, 1'b0, 16'h1234}) begin
        n_bad++;
        $display("FAIL hold_stable[%0d]: got %b %b %h want 1 0 1234", i, rsp_valid, req_ready, rsp_data);
      end
    end
    n_cmp++; if (we_cnt !== cnt0) begin n_bad++; $display("FAIL hold_no_access: got %0d want %0d", we_cnt, cnt0); end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req_ready, rsp_valid, rsp_data} !== {1'b1, 1'b0, 16'h0000}) begin n_bad++; $display("FAIL hold_release: got %b %b %h want 1 0 0000", req_ready, rsp_valid, rsp_data); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({req_ready, mem_we, mem_byte_en, mem_addr} !== {1'b0, 1'b1, 2'b11, 3'd0}) begin n_bad++; $display("FAIL hold_next_issue: got %b want 0111000", {req_ready, mem_we, mem_byte_en, mem_addr}); end
    w = 0;
    while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_next_rsp: got %b want 1", rsp_valid); end
    @(posedge clk); #1;
    n_cmp++; if (ram[0] !== 16'h7777) begin n_bad++; $display("FAIL hold_next_ram: got %h want 7777", ram[0]); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] prev;
`ifdef BYTE_RAM_MASTER_SPLIT_EN
    prev = ram[0];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 4'hF; req_wdata = 16'h9966;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({mem_we, mem_byte_en, mem_addr} !== {1'b1, 2'b01, 3'd0}) begin n_bad++; $display("FAIL mid_in_issue2: got %b want 101000", {mem_we, mem_byte_en, mem_addr}); end
`else
    prev = ram[3];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 4'h6; req_wdata = 16'hDEAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_we, mem_byte_en, mem_addr} !== {1'b1, 2'b11, 3'd3}) begin n_bad++; $display("FAIL mid_in_issue1: got %b want 111011", {mem_we, mem_byte_en, mem_addr}); end
`endif
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, mem_we, mem_byte_en, mem_addr, rsp_data, mem_data_in} !== {9'b1_0_0_0_00_000, 32'h0}) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %b %h %h want 100000000 0000 0000",
               {req_ready, rsp_valid, rsp_err, mem_we, mem_byte_en, mem_addr}, rsp_data, mem_data_in);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef BYTE_RAM_MASTER_SPLIT_EN
    n_cmp++; if ({ram[0], ram[7]} !== {prev, 16'h6607}) begin n_bad++; $display("FAIL mid_ram: got %h %h want %h 6607", ram[0], ram[7], prev); end
`else
    n_cmp++; if (ram[3] !== prev) begin n_bad++; $display("FAIL mid_ram: got %h want %h", ram[3], prev); end
`endif
    // reset while a response is pending drops it
    rsp_ready = 1'b0;
    do_req(1'b0, 1'b1, 4'h4, 16'h0000, 1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({rsp_valid, req_ready, rsp_data} !== {1'b0, 1'b1, 16'h0000}) begin n_bad++; $display("FAIL mid_rsp_drop: got %b %b %h want 0 1 0000", rsp_valid, req_ready, rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    do_req(1'b0, 1'b1, 4'h4, 16'h0000, 1'b0);
    n_cmp++; if ({lat[3:0], err_o, data_o} !== {4'd3, 1'b0, 16'h1234}) begin n_bad++; $display("FAIL mid_after_reset: got lat %0d %b/%h want 3 0/1234", lat, err_o, data_o); end
  endtask

  initial begin
    rst_n = 1'b0; ram_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0; req_addr = 4'h0; req_wdata = 16'h0;
    rsp_ready = 1'b1;
    test_reset;
    test_aligned_halfword;
    test_byte_lanes;
    test_misaligned;
    test_back_to_back;
    test_rsp_hold;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
